// File: rtl/pi_phase_code_ctrl.sv
// Phase-interpolator code controller for the CDR loop.
// Slews the live phase code toward a requested target along the shorter arc
// of the code circle, rate-limited by an update tick and step-limited per
// tick. Accepts single-LSB early/late nudges while idle. Decodes the live
// code into an adjacent one-hot phase pair plus the mixing weight.
module pi_phase_code_ctrl #(
    parameter int SECT_BITS  = 3,
    parameter int FRAC_BITS  = 8,
    parameter int UPD_DIV    = 4,
    parameter int MAX_STEP   = 1,
    parameter int SETTLE_CYC = 8,
    parameter int RST_CODE   = 0,
    localparam int CW        = SECT_BITS + FRAC_BITS,
    localparam int N         = 2 ** SECT_BITS
) (
    input  logic                 CLK,
    input  logic                 Rst_n,
    input  logic                 Tgt_Valid,
    input  logic [CW-1:0]        Tgt_Code,
    output logic                 Tgt_Ready,
    input  logic                 Step_Up,
    input  logic                 Step_Dn,
    output logic [CW-1:0]        Code_Cur,
    output logic [N-1:0]         Sel_A,
    output logic [N-1:0]         Sel_B,
    output logic [FRAC_BITS-1:0] Weight_B,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Wrap
);

    localparam int TW = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] HALF_C        = {1'b1, {(CW-1){1'b0}}};
    localparam logic [CW-1:0] MAX_STEP_C    = CW'(MAX_STEP);
    localparam logic [CW-1:0] RST_CODE_C    = CW'(RST_CODE);
    localparam logic [CW-1:0] CODE_MAX_C    = {CW{1'b1}};
    localparam logic [TW-1:0] TICK_LAST_C   = TW'(UPD_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST_C = SW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLEW   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e                 state_r;
    logic [TW-1:0]          tick_cnt_r;
    logic [SW-1:0]          settle_cnt_r;
    logic [CW-1:0]          code_r;
    logic [CW-1:0]          tgt_r;
    logic                   ready_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   wrap_r;

    logic                   tick_s;
    logic                   accept_s;
    logic [CW-1:0]          diff_s;
    logic                   dir_up_s;
    logic [CW-1:0]          dist_s;
    logic [CW-1:0]          step_s;
    logic                   landing_s;
    logic [CW:0]            up_sum_s;
    logic [CW:0]            dn_dif_s;
    logic [CW-1:0]          slew_code_s;
    logic                   slew_wrap_s;
    logic                   nudge_en_s;
    logic [CW-1:0]          nudge_code_s;
    logic                   nudge_wrap_s;
    logic [SECT_BITS-1:0]   sector_s;
    logic [SECT_BITS-1:0]   sector_nx_s;
    logic [N-1:0]           sel_a_s;
    logic [N-1:0]           sel_b_s;

    assign tick_s   = (tick_cnt_r == TICK_LAST_C);
    assign accept_s = Tgt_Valid & ready_r;

    // Free-running update divider; the code may only move on its last count.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            tick_cnt_r <= {TW{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TW{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Shortest-arc step toward the target; a half-circle tie resolves upward.
    always_comb begin
        diff_s    = tgt_r - code_r;
        dir_up_s  = (diff_s <= HALF_C);
        dist_s    = dir_up_s ? diff_s : ({CW{1'b0}} - diff_s);
        landing_s = (dist_s <= MAX_STEP_C);
        step_s    = landing_s ? dist_s : MAX_STEP_C;
        up_sum_s  = {1'b0, code_r} + {1'b0, step_s};
        dn_dif_s  = {1'b0, code_r} - {1'b0, step_s};
        if (dir_up_s) begin
            slew_code_s = up_sum_s[CW-1:0];
            slew_wrap_s = up_sum_s[CW];
        end else begin
            slew_code_s = dn_dif_s[CW-1:0];
            slew_wrap_s = dn_dif_s[CW];
        end
    end

    // Single-LSB nudge; opposing requests cancel.
    always_comb begin
        nudge_en_s = Step_Up ^ Step_Dn;
        if (Step_Up) begin
            nudge_code_s = code_r + CW'(1);
            nudge_wrap_s = (code_r == CODE_MAX_C);
        end else begin
            nudge_code_s = code_r - CW'(1);
            nudge_wrap_s = (code_r == {CW{1'b0}});
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r      <= ST_IDLE;
            code_r       <= RST_CODE_C;
            tgt_r        <= RST_CODE_C;
            settle_cnt_r <= {SW{1'b0}};
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wrap_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            wrap_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    if (accept_s) begin
                        tgt_r   <= Tgt_Code;
                        state_r <= ST_SLEW;
                        busy_r  <= 1'b1;
                    end else if (tick_s && nudge_en_s) begin
                        code_r <= nudge_code_s;
                        wrap_r <= nudge_wrap_s;
                    end
                end
                ST_SLEW: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b1;
                    if (accept_s) begin
                        tgt_r <= Tgt_Code;
                    end
                    // A target arriving on the landing tick keeps the slew alive.
                    if (tick_s) begin
                        if (diff_s != {CW{1'b0}}) begin
                            code_r <= slew_code_s;
                            wrap_r <= slew_wrap_s;
                        end
                        if ((diff_s == {CW{1'b0}} || landing_s) && !accept_s) begin
                            state_r      <= ST_SETTLE;
                            ready_r      <= 1'b0;
                            settle_cnt_r <= {SW{1'b0}};
                        end
                    end
                end
                ST_SETTLE: begin
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                    if (settle_cnt_r == SETTLE_LAST_C) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Sector decode: lower phase and its wrap-around neighbour.
    always_comb begin
        sector_s    = code_r[CW-1:FRAC_BITS];
        sector_nx_s = sector_s + SECT_BITS'(1);
        sel_a_s     = {N{1'b0}};
        sel_b_s     = {N{1'b0}};
        sel_a_s[sector_s]    = 1'b1;
        sel_b_s[sector_nx_s] = 1'b1;
    end

    assign Tgt_Ready = ready_r;
    assign Code_Cur  = code_r;
    assign Sel_A     = sel_a_s;
    assign Sel_B     = sel_b_s;
    assign Weight_B  = code_r[FRAC_BITS-1:0];
    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Wrap      = wrap_r;

endmodule

// File: tb/tb_pi_phase_code_ctrl.sv
// Directed bench for pi_phase_code_ctrl: reset, slew, wrap, tie/clamp,
// retarget and nudge scenarios with hand-computed expectations.
module tb_pi_phase_code_ctrl;

    logic        CLK = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Tgt_Valid = 1'b0;
    logic [10:0] Tgt_Code = 11'h000;
    logic        Step_Up = 1'b0;
    logic        Step_Dn = 1'b0;

    logic        Tgt_Ready, Busy, Done, Wrap;
    logic [10:0] Code_Cur;
    logic [7:0]  Sel_A, Sel_B, Weight_B;

    logic        Tgt_Ready3, Busy3, Done3, Wrap3;
    logic [10:0] Code_Cur3;
    logic [7:0]  Sel_A3, Sel_B3, Weight_B3;

    int checks = 0;
    int failures = 0;
    int pe = 0;

    always #5 CLK = ~CLK;

    pi_phase_code_ctrl dut (
        .CLK(CLK), .Rst_n(Rst_n), .Tgt_Valid(Tgt_Valid), .Tgt_Code(Tgt_Code),
        .Tgt_Ready(Tgt_Ready), .Step_Up(Step_Up), .Step_Dn(Step_Dn),
        .Code_Cur(Code_Cur), .Sel_A(Sel_A), .Sel_B(Sel_B), .Weight_B(Weight_B),
        .Busy(Busy), .Done(Done), .Wrap(Wrap)
    );

    pi_phase_code_ctrl #(.MAX_STEP(3)) dut3 (
        .CLK(CLK), .Rst_n(Rst_n), .Tgt_Valid(Tgt_Valid), .Tgt_Code(Tgt_Code),
        .Tgt_Ready(Tgt_Ready3), .Step_Up(Step_Up), .Step_Dn(Step_Dn),
        .Code_Cur(Code_Cur3), .Sel_A(Sel_A3), .Sel_B(Sel_B3), .Weight_B(Weight_B3),
        .Busy(Busy3), .Done(Done3), .Wrap(Wrap3)
    );

    // One clock; sample point is 2 time units after the rising edge.
    task automatic clk1();
        @(posedge CLK);
        #2;
        pe++;
    endtask

    task automatic run_to(input int n);
        while (pe < n) clk1();
    endtask

    task automatic do_reset();
        Rst_n = 1'b0; Tgt_Valid = 1'b0; Tgt_Code = 11'h000;
        Step_Up = 1'b0; Step_Dn = 1'b0;
        #13;
        @(posedge CLK);
        #2;
        Rst_n = 1'b1;
        pe = 0;
    endtask

    task automatic send(input logic [10:0] code);
        logic acc;
        logic ok;
        ok = 1'b0;
        Tgt_Code = code;
        Tgt_Valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            acc = Tgt_Ready;
            clk1();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        Tgt_Valid = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL send_accept code=%h accepted=%b expected=1", code, ok);
        end
    endtask

    task automatic test_reset();
        do_reset();
        run_to(2);
        send(11'h100);
        run_to(30);
        checks++; if (Code_Cur !== 11'h007) begin failures++; $display("FAIL t1_pre_code act=%h exp=007", Code_Cur); end
        #1 Rst_n = 1'b0;
        #1;
        checks++; if (Code_Cur !== 11'h000) begin failures++; $display("FAIL t1_code act=%h exp=000", Code_Cur); end
        checks++; if (Sel_A !== 8'h01 || Sel_B !== 8'h02) begin failures++; $display("FAIL t1_sel act=%h/%h exp=01/02", Sel_A, Sel_B); end
        checks++; if (Weight_B !== 8'h00) begin failures++; $display("FAIL t1_weight act=%h exp=00", Weight_B); end
        checks++; if ({Busy, Done, Wrap, Tgt_Ready} !== 4'b0000) begin failures++; $display("FAIL t1_flags act=%b exp=0000", {Busy, Done, Wrap, Tgt_Ready}); end
        @(posedge CLK);
        #2;
        Rst_n = 1'b1;
        pe = 0;
        run_to(12);
        checks++; if (Code_Cur !== 11'h000 || Busy !== 1'b0) begin failures++; $display("FAIL t1_post act=%h/%b exp=000/0", Code_Cur, Busy); end
    endtask

    task automatic test_up_slew();
        do_reset();
        run_to(2);
        send(11'h005);
        checks++; if (Busy !== 1'b1 || Code_Cur !== 11'h000) begin failures++; $display("FAIL t2_start act=%b/%h exp=1/000", Busy, Code_Cur); end
        run_to(4);
        checks++; if (Code_Cur !== 11'h001) begin failures++; $display("FAIL t2_tick1 act=%h exp=001", Code_Cur); end
        run_to(19);
        checks++; if (Code_Cur !== 11'h004) begin failures++; $display("FAIL t2_c19 act=%h exp=004", Code_Cur); end
        run_to(20);
        checks++; if (Code_Cur !== 11'h005 || Tgt_Ready !== 1'b0) begin failures++; $display("FAIL t2_land act=%h/%b exp=005/0", Code_Cur, Tgt_Ready); end
        checks++; if (Sel_A !== 8'h01 || Sel_B !== 8'h02 || Weight_B !== 8'h05) begin failures++; $display("FAIL t2_dec act=%h/%h/%h exp=01/02/05", Sel_A, Sel_B, Weight_B); end
        run_to(27);
        checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin failures++; $display("FAIL t2_settle act=%b/%b exp=1/0", Busy, Done); end
        run_to(28);
        checks++; if (Done !== 1'b1 || Busy !== 1'b0 || Code_Cur !== 11'h005) begin failures++; $display("FAIL t2_done act=%b/%b/%h exp=1/0/005", Done, Busy, Code_Cur); end
        run_to(29);
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL t2_done_pulse act=%b exp=0", Done); end
    endtask

    task automatic test_wrap();
        int wraps;
        do_reset();
        run_to(2);
        send(11'h002);
        run_to(16);
        checks++; if (Code_Cur !== 11'h002 || Done !== 1'b1) begin failures++; $display("FAIL t3_start act=%h/%b exp=002/1", Code_Cur, Done); end
        send(11'h7FE);
        wraps = 0;
        while (pe < 32) begin
            clk1();
            if (Wrap === 1'b1) wraps++;
            if (pe == 24) begin
                checks++; if (Code_Cur !== 11'h000 || Wrap !== 1'b0) begin failures++; $display("FAIL t3_zero act=%h/%b exp=000/0", Code_Cur, Wrap); end
            end
            if (pe == 28) begin
                checks++; if (Code_Cur !== 11'h7FF || Wrap !== 1'b1) begin failures++; $display("FAIL t3_wrap act=%h/%b exp=7FF/1", Code_Cur, Wrap); end
            end
        end
        checks++; if (wraps !== 1) begin failures++; $display("FAIL t3_wrap_count act=%0d exp=1", wraps); end
        checks++; if (Code_Cur !== 11'h7FE || Sel_A !== 8'h80 || Sel_B !== 8'h01 || Weight_B !== 8'hFE) begin
            failures++; $display("FAIL t3_end act=%h/%h/%h/%h exp=7FE/80/01/FE", Code_Cur, Sel_A, Sel_B, Weight_B);
        end
    endtask

    task automatic test_tie_clamp();
        do_reset();
        run_to(2);
        send(11'h400);
        run_to(4);
        checks++; if (Code_Cur3 !== 11'h003) begin failures++; $display("FAIL t4_first act=%h exp=003", Code_Cur3); end
        run_to(8);
        checks++; if (Code_Cur !== 11'h002) begin failures++; $display("FAIL t4_tie_step1 act=%h exp=002", Code_Cur); end
        run_to(1367);
        checks++; if (Code_Cur3 !== 11'h3FF || Busy3 !== 1'b1) begin failures++; $display("FAIL t4_pre act=%h/%b exp=3FF/1", Code_Cur3, Busy3); end
        run_to(1368);
        checks++; if (Code_Cur3 !== 11'h400 || Tgt_Ready3 !== 1'b0) begin failures++; $display("FAIL t4_land act=%h/%b exp=400/0", Code_Cur3, Tgt_Ready3); end
        run_to(1377);
        checks++; if (Code_Cur3 !== 11'h400 || Busy3 !== 1'b0) begin failures++; $display("FAIL t4_hold act=%h/%b exp=400/0", Code_Cur3, Busy3); end
    endtask

    task automatic test_retarget();
        do_reset();
        run_to(2);
        send(11'h100);
        run_to(64);
        checks++; if (Code_Cur !== 11'h010) begin failures++; $display("FAIL t5_mid act=%h exp=010", Code_Cur); end
        send(11'h008);
        run_to(67);
        checks++; if (Code_Cur !== 11'h010) begin failures++; $display("FAIL t5_hold act=%h exp=010", Code_Cur); end
        run_to(68);
        checks++; if (Code_Cur !== 11'h00F) begin failures++; $display("FAIL t5_reverse act=%h exp=00F", Code_Cur); end
        run_to(96);
        checks++; if (Code_Cur !== 11'h008 || Tgt_Ready !== 1'b0) begin failures++; $display("FAIL t5_land act=%h/%b exp=008/0", Code_Cur, Tgt_Ready); end
        run_to(104);
        checks++; if (Done !== 1'b1 || Code_Cur !== 11'h008) begin failures++; $display("FAIL t5_done act=%b/%h exp=1/008", Done, Code_Cur); end
    endtask

    task automatic test_nudge();
        do_reset();
        run_to(2);
        send(11'h0FF);
        run_to(1029);
        checks++; if (Code_Cur !== 11'h0FF || Busy !== 1'b0) begin failures++; $display("FAIL t6_idle act=%h/%b exp=0FF/0", Code_Cur, Busy); end
        Step_Up = 1'b1;
        run_to(1031);
        checks++; if (Code_Cur !== 11'h0FF || Sel_A !== 8'h01) begin failures++; $display("FAIL t6_notick act=%h/%h exp=0FF/01", Code_Cur, Sel_A); end
        run_to(1032);
        checks++; if (Code_Cur !== 11'h100 || Sel_A !== 8'h02 || Sel_B !== 8'h04 || Weight_B !== 8'h00) begin
            failures++; $display("FAIL t6_up act=%h/%h/%h/%h exp=100/02/04/00", Code_Cur, Sel_A, Sel_B, Weight_B);
        end
        Step_Dn = 1'b1;
        run_to(1036);
        checks++; if (Code_Cur !== 11'h100) begin failures++; $display("FAIL t6_both act=%h exp=100", Code_Cur); end
        Step_Up = 1'b0;
        run_to(1040);
        checks++; if (Code_Cur !== 11'h0FF || Sel_A !== 8'h01 || Busy !== 1'b0) begin failures++; $display("FAIL t6_dn act=%h/%h/%b exp=0FF/01/0", Code_Cur, Sel_A, Busy); end
        Step_Dn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_slew();
        test_wrap();
        test_tie_clamp();
        test_retarget();
        test_nudge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
